div_unit: RTL

- Iterative restoring divider for the RV32M DIV/DIVU/REM/REMU instructions.
- Sits directly beside the ALU adder and reuses an add_sub instance (Cin=1, subtract) as its per-step trial subtractor.
- Operands are sampled on a start pulse. The block computes one quotient bit per cycle and returns the selected quotient or remainder with a one-cycle valid pulse.
- A multi-cycle stall controller holds the pipeline while o_busy is high.

---
 rtl/div_unit.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
// Module  : div_unit (with helper add_sub)
// Brief   : Iterative restoring divider for RV32M DIV/DIVU/REM/REMU.
//           Produces one quotient bit per cycle through a shared add_sub
//           trial subtractor. The selected quotient or remainder is
//           returned with a one-cycle valid pulse.
// Revision: 1.0 - initial release
// ============================================================================

// Adder/subtractor. When i_sub=1 it computes i_a - i_b as i_a + ~i_b + 1.
module add_sub #(
  parameter int WIDTH = 33
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_sub,
  output logic [WIDTH-1:0] o_sum
);
  assign o_sum = i_a + (i_b ^ {WIDTH{i_sub}}) + {{(WIDTH-1){1'b0}}, i_sub};
endmodule

module div_unit #(
  parameter int DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [1:0]        i_op,
  input  logic [DATA_W-1:0] i_op_a,
  input  logic [DATA_W-1:0] i_op_b,
  output logic              o_busy,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_result
);

  localparam int                CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W - 1);
  localparam logic [DATA_W-1:0] C_MIN    = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                rem_sel_q, rem_sel_d;   // 1: return remainder
  logic                neg_q_q, neg_q_d;       // negate quotient in FIX
  logic                neg_r_q, neg_r_d;       // negate remainder in FIX
  logic                special_q, special_d;   // quo_q holds a preloaded result
  logic [DATA_W-1:0]   quo_q, quo_d;           // dividend shifts out, quotient in
  logic [DATA_W:0]     rem_q, rem_d;
  logic [DATA_W-1:0]   dvsr_q, dvsr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   result_q, result_d;

  logic              w_accept;
  logic              w_signed, w_sa, w_sb;
  logic              w_div0, w_ovf;
  logic [DATA_W-1:0] w_abs_a, w_abs_b, w_special;
  logic [DATA_W:0]   w_rem_sh, w_trial;
  logic [DATA_W-1:0] w_quo_fix, w_rem_fix;
  logic              w_rem_msb_unused;

  // Restoring steps keep the remainder below the divisor, so its top bit
  // only matters transiently inside the trial subtraction.
  assign w_rem_msb_unused = rem_q[DATA_W];

  // Operand conditioning for an incoming start
  assign w_accept  = i_start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign w_signed  = ~i_op[0];
  assign w_sa      = w_signed & i_op_a[DATA_W-1];
  assign w_sb      = w_signed & i_op_b[DATA_W-1];
  assign w_abs_a   = w_sa ? -i_op_a : i_op_a;
  assign w_abs_b   = w_sb ? -i_op_b : i_op_b;
  assign w_div0    = (i_op_b == '0);
  assign w_ovf     = w_signed && (i_op_a == C_MIN) && (i_op_b == '1);
  assign w_special = w_div0 ? (i_op[1] ? i_op_a : '1)
                            : (i_op[1] ? '0     : C_MIN);

  // Trial subtraction: shifted partial remainder minus the zero-extended divisor
  assign w_rem_sh = {rem_q[DATA_W-1:0], quo_q[DATA_W-1]};

  add_sub #(.WIDTH(DATA_W + 1)) u_trial_sub (
    .i_a   (w_rem_sh),
    .i_b   ({1'b0, dvsr_q}),
    .i_sub (1'b1),
    .o_sum (w_trial)
  );

  // Sign restoration: quotient by sign mismatch, remainder follows the dividend
  assign w_quo_fix = neg_q_q ? -quo_q : quo_q;
  assign w_rem_fix = neg_r_q ? -rem_q[DATA_W-1:0] : rem_q[DATA_W-1:0];

  // State register and datapath registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      rem_sel_q <= 1'b0;
      neg_q_q   <= 1'b0;
      neg_r_q   <= 1'b0;
      special_q <= 1'b0;
      quo_q     <= '0;
      rem_q     <= '0;
      dvsr_q    <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      rem_sel_q <= rem_sel_d;
      neg_q_q   <= neg_q_d;
      neg_r_q   <= neg_r_d;
      special_q <= special_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      dvsr_q    <= dvsr_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
    end
  end

  // Next-state and datapath update for each state
  always_comb begin
    state_d   = state_q;
    rem_sel_d = rem_sel_q;
    neg_q_d   = neg_q_q;
    neg_r_d   = neg_r_q;
    special_d = special_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dvsr_d    = dvsr_q;
    cnt_d     = cnt_q;
    result_d  = result_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (w_accept) begin
          rem_sel_d = i_op[1];
          neg_q_d   = w_sa ^ w_sb;
          neg_r_d   = w_sa;
          special_d = w_div0 | w_ovf;
          dvsr_d    = w_abs_b;
          rem_d     = '0;
          cnt_d     = '0;
          if (w_div0 || w_ovf) begin
            quo_d   = w_special;
            state_d = S_FIX;
          end else begin
            quo_d   = w_abs_a;
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (!w_trial[DATA_W]) begin
          rem_d = w_trial;
          quo_d = {quo_q[DATA_W-2:0], 1'b1};
        end else begin
          rem_d = w_rem_sh;
          quo_d = {quo_q[DATA_W-2:0], 1'b0};
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        if (special_q) begin
          result_d = quo_q;
        end else begin
          result_d = rem_sel_q ? w_rem_fix : w_quo_fix;
        end
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign o_busy   = (state_q == S_CALC) || (state_q == S_FIX);
  assign o_valid  = (state_q == S_DONE);
  assign o_result = result_q;

endmodule
`default_nettype wire
